// File: rtl/usb_packet_checker_if.sv
// Output stream of usb_packet_checker: checked payload, PID nibble and error
// flags, qualified by a valid/ready handshake.
// Optional build macro DATA_TOGGLE_CHECK_EN adds the seq_err flag.
interface usb_packet_checker_if #(
  parameter int DATA_BITS = 64
);
  logic                 out_valid;
  logic                 out_ready;
  logic [DATA_BITS-1:0] out_data;
  logic [3:0]           out_pid;
  logic                 pid_err;
  logic                 crc_err;
`ifdef DATA_TOGGLE_CHECK_EN
  logic                 seq_err;

  modport master (
    output out_valid, out_data, out_pid, pid_err, crc_err, seq_err,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_pid, pid_err, crc_err, seq_err,
    output out_ready
  );
`else
  modport master (
    output out_valid, out_data, out_pid, pid_err, crc_err,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_data, out_pid, pid_err, crc_err,
    output out_ready
  );
`endif
endinterface

// File: rtl/usb_packet_checker.sv
// usb_packet_checker: captures PID/payload/CRC on the rising edge of
// eop_found, checks the PID check nibble, recomputes CRC16 one payload bit
// per cycle (data[0] first) and presents the result on a valid/ready stream.
// Optional build macro DATA_TOGGLE_CHECK_EN adds DATA0/DATA1 sequence checking
// (seq_err on the output interface plus an expected-toggle register).
module usb_packet_checker #(
  parameter int          DATA_BITS = 64,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           pid_data,
  input  logic [DATA_BITS-1:0] data,
  input  logic [15:0]          crc_data,
  input  logic                 eop_found,
  usb_packet_checker_if.master out_if,
  output logic                 busy,
  output logic                 overflow
);

  // Counter must reach DATA_BITS itself: the cycle at DATA_BITS is the
  // hand-off into CHECK, which yields the DATA_BITS+2 edge latency.
  localparam int CNT_W = $clog2(DATA_BITS + 1);
  localparam int IDX_W = $clog2(DATA_BITS);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CRC   = 2'd1,
    CHECK = 2'd2,
    HOLD  = 2'd3
  } state_t;

  // One serial CRC16 step (poly 0x8005, MSB-first register).
  function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic bit_in);
    logic fb;
    fb = bit_in ^ crc[15];
    return {crc[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
  endfunction

  // High nibble of a PID byte must be the complement of the low nibble.
  function automatic logic pid_check_bad(input logic [7:0] pid);
    return (pid[7:4] != ~pid[3:0]);
  endfunction

  state_t               state_r;
  state_t               state_next_s;
  logic                 eop_q_r;
  logic                 eop_rise_s;
  logic                 handshake_s;
  logic                 crc_done_s;
  logic                 bit_s;
  logic [7:0]           pid_r;
  logic [DATA_BITS-1:0] data_r;
  logic [15:0]          crc_rx_r;
  logic [15:0]          crc_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 out_valid_r;
  logic [DATA_BITS-1:0] out_data_r;
  logic [3:0]           out_pid_r;
  logic                 pid_err_r;
  logic                 crc_err_r;
  logic                 busy_r;
  logic                 overflow_r;
`ifdef DATA_TOGGLE_CHECK_EN
  logic                 seq_err_r;
  logic                 exp_tog_r;   // 0: expect DATA0, 1: expect DATA1
  logic                 is_data_s;

  assign is_data_s      = (pid_r[3:0] == 4'b0011) || (pid_r[3:0] == 4'b1011);
  assign out_if.seq_err = seq_err_r;
`endif

  assign eop_rise_s  = eop_found & ~eop_q_r;
  assign handshake_s = out_valid_r & out_if.out_ready;
  assign crc_done_s  = (cnt_r == CNT_W'(DATA_BITS));
  assign bit_s       = data_r[cnt_r[IDX_W-1:0]];

  assign out_if.out_valid = out_valid_r;
  assign out_if.out_data  = out_data_r;
  assign out_if.out_pid   = out_pid_r;
  assign out_if.pid_err   = pid_err_r;
  assign out_if.crc_err   = crc_err_r;
  assign busy             = busy_r;
  assign overflow         = overflow_r;

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (eop_rise_s) state_next_s = CRC;
        else            state_next_s = IDLE;
      end
      CRC: begin
        if (crc_done_s) state_next_s = CHECK;
        else            state_next_s = CRC;
      end
      CHECK: state_next_s = HOLD;
      HOLD: begin
        if (handshake_s) state_next_s = IDLE;
        else             state_next_s = HOLD;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Capture, serial CRC, result loading and handshake bookkeeping.
  always_ff @(posedge clk) begin
    if (rst) begin
      eop_q_r     <= 1'b0;
      pid_r       <= 8'h00;
      data_r      <= {DATA_BITS{1'b0}};
      crc_rx_r    <= 16'h0000;
      crc_r       <= 16'h0000;
      cnt_r       <= {CNT_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {DATA_BITS{1'b0}};
      out_pid_r   <= 4'h0;
      pid_err_r   <= 1'b0;
      crc_err_r   <= 1'b0;
      busy_r      <= 1'b0;
      overflow_r  <= 1'b0;
`ifdef DATA_TOGGLE_CHECK_EN
      seq_err_r   <= 1'b0;
      exp_tog_r   <= 1'b0;
`endif
    end else begin
      eop_q_r    <= eop_found;
      overflow_r <= eop_rise_s && (state_r != IDLE);
      busy_r     <= (state_next_s != IDLE);
      case (state_r)
        IDLE: begin
          if (eop_rise_s) begin
            pid_r    <= pid_data;
            data_r   <= data;
            crc_rx_r <= crc_data;
            crc_r    <= CRC_INIT;
            cnt_r    <= {CNT_W{1'b0}};
          end
        end
        CRC: begin
          if (!crc_done_s) begin
            crc_r <= crc16_step(crc_r, bit_s);
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        CHECK: begin
          out_valid_r <= 1'b1;
          out_data_r  <= data_r;
          out_pid_r   <= pid_r[3:0];
          crc_err_r   <= (crc_rx_r != ~crc_r);
          pid_err_r   <= pid_check_bad(pid_r);
`ifdef DATA_TOGGLE_CHECK_EN
          seq_err_r   <= is_data_s ? (pid_r[3] != exp_tog_r) : 1'b0;
`endif
        end
        HOLD: begin
          if (handshake_s) begin
            out_valid_r <= 1'b0;
            pid_err_r   <= 1'b0;
            crc_err_r   <= 1'b0;
`ifdef DATA_TOGGLE_CHECK_EN
            seq_err_r   <= 1'b0;
            if (is_data_s && !pid_err_r && !crc_err_r && !seq_err_r) begin
              exp_tog_r <= ~exp_tog_r;
            end
`endif
          end
        end
        default: begin
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_usb_packet_checker.sv
// Self-checking bench for usb_packet_checker with a randomized packet mix and
// a behavioural CRC16/PID/toggle model.
module tb_usb_packet_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pid_data;
  logic [63:0] data;
  logic [15:0] crc_data;
  logic        eop_found;
  logic        busy;
  logic        overflow;

  int n_cmp = 0;
  int n_bad = 0;

  usb_packet_checker_if #(.DATA_BITS(64)) out_if ();

  usb_packet_checker #(.DATA_BITS(64), .CRC_INIT(16'hFFFF)) dut (
    .clk       (clk),
    .rst       (rst),
    .pid_data  (pid_data),
    .data      (data),
    .crc_data  (crc_data),
    .eop_found (eop_found),
    .out_if    (out_if.master),
    .busy      (busy),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  // CRC16 over the payload, data[0] first, seed 0xFFFF, poly 0x8005, done as
  // integer shift-and-reduce.
  function automatic logic [15:0] model_crc(input logic [63:0] d);
    int unsigned r;
    r = 32'h0000FFFF;
    for (int i = 0; i < 64; i++) begin
      r = r << 1;
      if (((r >> 16) & 32'd1) != {31'd0, d[i]}) r = r ^ 32'h00008005;
      r = r & 32'h0000FFFF;
    end
    return r[15:0];
  endfunction

  function automatic logic model_pid_bad(input logic [7:0] p);
    logic [3:0] lo;
    logic [3:0] hi;
    lo = p[3:0];
    hi = p[7:4];
    return (hi + lo) != 4'hF;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Present a packet and raise eop_found; returns just after the capture edge.
  task automatic send(input logic [7:0] p, input logic [63:0] d, input logic [15:0] c);
    pid_data  = p;
    data      = d;
    crc_data  = c;
    eop_found = 1'b1;
    tick();
    eop_found = 1'b0;
  endtask

  // Count edges until out_valid appears (bounded).
  task automatic wait_valid(output int lat);
    lat = 0;
    while (out_if.out_valid !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick();
    tick();
    n_cmp++; if (out_if.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", out_if.out_valid); end
    n_cmp++; if (out_if.out_data !== 64'h0) begin n_bad++; $display("FAIL reset_data: got %h want 0", out_if.out_data); end
    n_cmp++; if (out_if.out_pid !== 4'h0) begin n_bad++; $display("FAIL reset_pid: got %h want 0", out_if.out_pid); end
    n_cmp++; if ({out_if.pid_err, out_if.crc_err} !== 2'b00) begin n_bad++; $display("FAIL reset_errs: got %b want 00", {out_if.pid_err, out_if.crc_err}); end
    n_cmp++; if ({busy, overflow} !== 2'b00) begin n_bad++; $display("FAIL reset_busy_ovf: got %b want 00", {busy, overflow}); end
`ifdef DATA_TOGGLE_CHECK_EN
    n_cmp++; if (out_if.seq_err !== 1'b0) begin n_bad++; $display("FAIL reset_seq: got %b want 0", out_if.seq_err); end
`endif
    rst = 1'b0;
    tick();
  endtask

  task automatic test_basic;
    int lat;
    out_if.out_ready = 1'b1;
    send(8'hC3, 64'h0, ~model_crc(64'h0));
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL basic_busy: got %b want 1", busy); end
    wait_valid(lat);
    n_cmp++; if (lat != 66) begin n_bad++; $display("FAIL basic_latency: got %0d want 66", lat); end
    n_cmp++; if (out_if.out_pid !== 4'h3) begin n_bad++; $display("FAIL basic_pid: got %h want 3", out_if.out_pid); end
    n_cmp++; if ({out_if.pid_err, out_if.crc_err} !== 2'b00) begin n_bad++; $display("FAIL basic_errs: got %b want 00", {out_if.pid_err, out_if.crc_err}); end
    n_cmp++; if (out_if.out_data !== 64'h0) begin n_bad++; $display("FAIL basic_data: got %h want 0", out_if.out_data); end
    tick();
    n_cmp++; if ({out_if.out_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL basic_one_cycle: got %b want 00", {out_if.out_valid, busy}); end
  endtask

  task automatic test_errors;
    int lat;
    out_if.out_ready = 1'b1;
    send(8'hC3, 64'h0, ~model_crc(64'h0) ^ 16'h0001);
    wait_valid(lat);
    n_cmp++; if ({out_if.pid_err, out_if.crc_err} !== 2'b01) begin n_bad++; $display("FAIL err_crc: got %b want 01", {out_if.pid_err, out_if.crc_err}); end
    tick();
    n_cmp++; if ({out_if.pid_err, out_if.crc_err} !== 2'b00) begin n_bad++; $display("FAIL err_clear: got %b want 00", {out_if.pid_err, out_if.crc_err}); end
    send(8'hC2, 64'h0, ~model_crc(64'h0));
    wait_valid(lat);
    n_cmp++; if ({out_if.pid_err, out_if.crc_err} !== 2'b10) begin n_bad++; $display("FAIL err_pid: got %b want 10", {out_if.pid_err, out_if.crc_err}); end
    n_cmp++; if (out_if.out_pid !== 4'h2) begin n_bad++; $display("FAIL err_pid_val: got %h want 2", out_if.out_pid); end
    tick();
  endtask

  task automatic test_random;
    int lat;
    logic [3:0]  n;
    logic [7:0]  p;
    logic [63:0] d;
    logic [15:0] c;
    for (int k = 0; k < 8; k++) begin
      n = 4'($urandom_range(0, 15));
      p = ($urandom_range(0, 1) == 0) ? {~n, n} : 8'($urandom);
      d = {32'($urandom), 32'($urandom)};
      c = ~model_crc(d);
      if ($urandom_range(0, 2) == 0) c = c ^ (16'h0001 << $urandom_range(0, 15));
      out_if.out_ready = 1'b0;
      send(p, d, c);
      wait_valid(lat);
      n_cmp++; if (lat != 66) begin n_bad++; $display("FAIL rnd_latency[%0d]: got %0d want 66", k, lat); end
      n_cmp++; if (out_if.out_data !== d) begin n_bad++; $display("FAIL rnd_data[%0d]: got %h want %h", k, out_if.out_data, d); end
      n_cmp++; if (out_if.out_pid !== p[3:0]) begin n_bad++; $display("FAIL rnd_pid[%0d]: got %h want %h", k, out_if.out_pid, p[3:0]); end
      n_cmp++; if (out_if.pid_err !== model_pid_bad(p)) begin n_bad++; $display("FAIL rnd_pid_err[%0d]: got %b want %b", k, out_if.pid_err, model_pid_bad(p)); end
      n_cmp++; if (out_if.crc_err !== (c != ~model_crc(d))) begin n_bad++; $display("FAIL rnd_crc_err[%0d]: got %b want %b", k, out_if.crc_err, (c != ~model_crc(d))); end
      repeat ($urandom_range(0, 4)) tick();
      n_cmp++; if (out_if.out_valid !== 1'b1) begin n_bad++; $display("FAIL rnd_hold[%0d]: got %b want 1", k, out_if.out_valid); end
      out_if.out_ready = 1'b1;
      tick();
      n_cmp++; if ({out_if.out_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL rnd_release[%0d]: got %b want 00", k, {out_if.out_valid, busy}); end
    end
  endtask

  task automatic test_backpressure;
    int lat;
    logic [63:0] d;
    d = {32'($urandom), 32'($urandom)};
    out_if.out_ready = 1'b0;
    send(8'hD2, d, ~model_crc(d));
    wait_valid(lat);
    for (int i = 0; i < 10; i++) begin
      if (i == 3) begin
        pid_data  = 8'hC3;
        data      = ~d;
        crc_data  = 16'h1234;
        eop_found = 1'b1;
      end
      tick();
      if (i == 3) eop_found = 1'b0;
      n_cmp++; if ({out_if.out_valid, busy} !== 2'b11) begin n_bad++; $display("FAIL bp_valid_busy[%0d]: got %b want 11", i, {out_if.out_valid, busy}); end
      n_cmp++; if (out_if.out_data !== d || out_if.out_pid !== 4'h2) begin n_bad++; $display("FAIL bp_stable[%0d]: got %h/%h want %h/2", i, out_if.out_data, out_if.out_pid, d); end
      n_cmp++; if (overflow !== (i == 3)) begin n_bad++; $display("FAIL bp_overflow[%0d]: got %b want %b", i, overflow, (i == 3)); end
    end
    out_if.out_ready = 1'b1;
    tick();
    n_cmp++; if ({out_if.out_valid, busy} !== 2'b00) begin n_bad++; $display("FAIL bp_release: got %b want 00", {out_if.out_valid, busy}); end
  endtask

  task automatic test_back_to_back;
    int lat;
    logic [63:0] da;
    logic [63:0] db;
    da = {32'($urandom), 32'($urandom)};
    db = {32'($urandom), 32'($urandom)};
    out_if.out_ready = 1'b0;
    send(8'hE1, da, ~model_crc(da));
    wait_valid(lat);
    pid_data         = 8'h4B;
    data             = db;
    crc_data         = ~model_crc(db);
    eop_found        = 1'b1;
    out_if.out_ready = 1'b1;
    tick();
    n_cmp++; if ({out_if.out_valid, overflow, busy} !== 3'b010) begin n_bad++; $display("FAIL b2b_drop: got %b want 010", {out_if.out_valid, overflow, busy}); end
    eop_found = 1'b0;
    tick();
    n_cmp++; if ({busy, overflow} !== 2'b00) begin n_bad++; $display("FAIL b2b_idle: got %b want 00", {busy, overflow}); end
    send(8'h4B, db, ~model_crc(db));
    wait_valid(lat);
    n_cmp++; if (lat != 66) begin n_bad++; $display("FAIL b2b_latency: got %0d want 66", lat); end
    n_cmp++; if (out_if.out_data !== db) begin n_bad++; $display("FAIL b2b_data: got %h want %h", out_if.out_data, db); end
    tick();
  endtask

  task automatic test_reset_mid;
    int lat;
    logic [63:0] d;
    d = {32'($urandom), 32'($urandom)};
    out_if.out_ready = 1'b1;
    pid_data  = 8'hC3;
    data      = d;
    crc_data  = ~model_crc(d);
    eop_found = 1'b1;
    tick();
    repeat (30) tick();
    n_cmp++; if (busy !== 1'b1) begin n_bad++; $display("FAIL rstmid_busy: got %b want 1", busy); end
    rst = 1'b1;
    tick();
    n_cmp++; if ({out_if.out_valid, busy, overflow, out_if.pid_err, out_if.crc_err} !== 5'b0) begin n_bad++; $display("FAIL rstmid_flags: got %b want 00000", {out_if.out_valid, busy, overflow, out_if.pid_err, out_if.crc_err}); end
    n_cmp++; if (out_if.out_data !== 64'h0 || out_if.out_pid !== 4'h0) begin n_bad++; $display("FAIL rstmid_data: got %h/%h want 0/0", out_if.out_data, out_if.out_pid); end
    rst = 1'b0;
    tick();
    wait_valid(lat);
    n_cmp++; if (lat != 66) begin n_bad++; $display("FAIL rstmid_latency: got %0d want 66", lat); end
    n_cmp++; if (out_if.out_data !== d || out_if.crc_err !== 1'b0) begin n_bad++; $display("FAIL rstmid_result: got %h/%b want %h/0", out_if.out_data, out_if.crc_err, d); end
    eop_found = 1'b0;
    tick();
  endtask

`ifdef DATA_TOGGLE_CHECK_EN
  task automatic test_toggle;
    int lat;
    logic exp_tog;
    logic is_data;
    logic want_seq;
    logic bad_crc;
    logic [7:0]  p;
    logic [63:0] d;
    logic [15:0] c;
    logic [7:0]  seq_tbl [5];
    seq_tbl[0] = 8'hC3; seq_tbl[1] = 8'h4B; seq_tbl[2] = 8'h4B; seq_tbl[3] = 8'hC3; seq_tbl[4] = 8'h4B;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    exp_tog = 1'b0;
    out_if.out_ready = 1'b1;
    for (int k = 0; k < 11; k++) begin
      if (k < 5) begin
        p = seq_tbl[k];
        bad_crc = 1'b0;
      end else begin
        case ($urandom_range(0, 2))
          0:       p = 8'hC3;
          1:       p = 8'h4B;
          default: p = 8'hD2;
        endcase
        bad_crc = ($urandom_range(0, 3) == 0);
      end
      d = {32'($urandom), 32'($urandom)};
      c = ~model_crc(d) ^ (bad_crc ? 16'h8000 : 16'h0000);
      is_data  = (p == 8'hC3) || (p == 8'h4B);
      want_seq = is_data && ((p == 8'h4B) != exp_tog);
      send(p, d, c);
      wait_valid(lat);
      n_cmp++; if (out_if.seq_err !== want_seq) begin n_bad++; $display("FAIL tog_seq[%0d]: got %b want %b", k, out_if.seq_err, want_seq); end
      tick();
      n_cmp++; if (out_if.seq_err !== 1'b0) begin n_bad++; $display("FAIL tog_clear[%0d]: got %b want 0", k, out_if.seq_err); end
      if (is_data && !bad_crc && !want_seq) exp_tog = ~exp_tog;
    end
  endtask
`endif

  initial begin
    rst              = 1'b1;
    pid_data         = 8'h00;
    data             = 64'h0;
    crc_data         = 16'h0000;
    eop_found        = 1'b0;
    out_if.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_errors();
    test_random();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
`ifdef DATA_TOGGLE_CHECK_EN
    test_toggle();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
